// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Round-robin arbiter that funnels per-FU completions onto a single
//            common data bus, one broadcast per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter  int NUM_FU = 4,
    parameter  int TAG_W  = 6,
    localparam int IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int CNT_W  = $clog2(NUM_FU + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    flush,
    input  logic [NUM_FU-1:0]       fu_done,
    input  logic [NUM_FU*TAG_W-1:0] fu_tag,
    output logic [NUM_FU-1:0]       fu_ready,
    output logic                    CAM_en,
    output logic [TAG_W-1:0]        CDB_in,
    output logic [IDX_W-1:0]        cdb_fu_idx,
    output logic [CNT_W-1:0]        pending_cnt
);

    localparam logic [TAG_W-1:0] c_dummy_tag = '1;
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(NUM_FU - 1);
    localparam logic [IDX_W:0]   c_num_fu    = (IDX_W + 1)'(NUM_FU);

    logic [NUM_FU-1:0] r_valid;
    logic [TAG_W-1:0]  r_tag [NUM_FU];
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0]  r_pending_cnt;

    logic                w_live;
    logic [2*NUM_FU-1:0] w_valid_dbl;
    logic [NUM_FU-1:0]   w_valid_rot;
    logic [IDX_W-1:0]    w_offset;
    logic [IDX_W:0]      w_sum;
    logic                w_grant_vld;
    logic [IDX_W-1:0]    w_grant_idx;
    logic [NUM_FU-1:0]   w_grant;
    logic [NUM_FU-1:0]   w_accept;
    logic [NUM_FU-1:0]   w_load;
    logic [NUM_FU-1:0]   w_valid_nxt;
    logic [IDX_W-1:0]    w_rr_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    // Reset is folded in so every output is quiet while reset is held.
    assign w_live = enable & ~flush & ~reset;

    // Rotating the doubled valid vector puts rr_ptr at bit 0, so a plain
    // lowest-bit-first search yields the round-robin offset.
    assign w_valid_dbl = {r_valid, r_valid};
    assign w_valid_rot = NUM_FU'(w_valid_dbl >> r_rr_ptr);

    always_comb begin
        w_offset = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (w_valid_rot[k]) begin
                w_offset = IDX_W'(k);
            end
        end
    end

    assign w_sum       = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    assign w_grant_idx = (w_sum >= c_num_fu) ? IDX_W'(w_sum - c_num_fu) : w_sum[IDX_W-1:0];
    assign w_grant_vld = w_live & (|r_valid);
    assign w_grant     = w_grant_vld ? (NUM_FU'(1) << w_grant_idx) : '0;

    // An entry being drained this cycle may be refilled on the same edge.
    assign fu_ready = {NUM_FU{w_live}} & (~r_valid | w_grant);
    assign w_accept = fu_done & fu_ready;

    generate
        for (genvar i = 0; i < NUM_FU; i++) begin : g_entry
            assign w_load[i] = w_accept[i] & (fu_tag[i*TAG_W +: TAG_W] != c_dummy_tag);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_tag[i] <= c_dummy_tag;
                end else if (w_load[i]) begin
                    r_tag[i] <= fu_tag[i*TAG_W +: TAG_W];
                end
            end
        end
    endgenerate

    always_comb begin
        w_valid_nxt = r_valid;
        if (flush) begin
            w_valid_nxt = '0;
        end else if (enable) begin
            // Accepted DUMMY completions leave the entry invalid.
            w_valid_nxt = (r_valid & ~w_grant & ~w_accept) | w_load;
        end
    end

    always_comb begin
        w_rr_nxt = r_rr_ptr;
        if (w_grant_vld) begin
            w_rr_nxt = (w_grant_idx == c_last_idx) ? '0 : (w_grant_idx + IDX_W'(1));
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_valid_nxt[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid       <= '0;
            r_rr_ptr      <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_valid       <= w_valid_nxt;
            r_rr_ptr      <= w_rr_nxt;
            r_pending_cnt <= w_cnt_nxt;
        end
    end

    assign CAM_en      = w_grant_vld;
    assign CDB_in      = w_grant_vld ? r_tag[w_grant_idx] : c_dummy_tag;
    assign cdb_fu_idx  = w_grant_vld ? w_grant_idx : '0;
    assign pending_cnt = r_pending_cnt;

`ifndef SYNTHESIS
    a_grant_onehot : assert property (@(posedge clock) disable iff (reset) $onehot0(w_grant));
    a_cnt_range    : assert property (@(posedge clock) disable iff (reset)
                                      r_pending_cnt <= CNT_W'(NUM_FU));
`endif

endmodule
`default_nettype wire
